// File: rtl/pipe_scroller.sv
// -----------------------------------------------------------------------------
// pipe_scroller
//
// Game-state controller for a side-scrolling pipe obstacle. A three-state FSM
// (IDLE / RUN / OVER) moves one pipe leftwards by SPEED pixels on each game
// tick. When the pipe reaches the left edge it respawns off the right edge
// with a new pseudo-random opening, and the score counts up (saturating).
//
// Ports
//   clk          in   1   sole clock, rising edge
//   reset        in   1   asynchronous, active-high reset
//   start_button in   1   button level, already synchronous to clk
//   tick         in   1   one-cycle game-tick strobe
//   collided     in   1   level from the collision stage
//   pipe_x       out  10  pipe centre x
//   pipe_y_top   out  10  upper edge of the opening
//   pipe_y_bot   out  10  lower edge of the opening
//   score        out  8   pipes passed, saturates at 255
//   running      out  1   high while in RUN
//   game_over    out  1   high while in OVER
// -----------------------------------------------------------------------------
module pipe_scroller #(
  parameter int unsigned SCREEN_W  = 32'd640,
  parameter int unsigned PIPE_HALF = 32'd50,
  parameter int unsigned SPEED     = 32'd4,
  parameter int unsigned GAP       = 32'd120,
  parameter int unsigned GAP_MIN   = 32'd40
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start_button,
  input  logic       tick,
  input  logic       collided,
  output logic [9:0] pipe_x,
  output logic [9:0] pipe_y_top,
  output logic [9:0] pipe_y_bot,
  output logic [7:0] score,
  output logic       running,
  output logic       game_over
);

  // Respawn just past the right edge so the pipe slides in from off-screen.
  localparam logic [9:0] SPAWN_X_C = 10'(SCREEN_W + PIPE_HALF);
  localparam logic [9:0] SPEED_C   = 10'(SPEED);
  localparam logic [9:0] GAP_C     = 10'(GAP);
  localparam logic [9:0] GAP_MIN_C = 10'(GAP_MIN);
  localparam logic [7:0] LFSR_SEED = 8'hA5;
  localparam logic [9:0] RST_TOP_C = 10'd180;
  localparam logic [9:0] RST_BOT_C = 10'd300;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    OVER = 2'd2
  } state_t;

  // 8-bit Fibonacci LFSR step, taps 8,6,5,4 (bits 7,5,4,3).
  function automatic logic [7:0] lfsr_next(input logic [7:0] v);
    return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
  endfunction

  state_t      state_r, state_n_s;
  logic        start_d_r;
  logic [7:0]  lfsr_r;
  logic [9:0]  pipe_x_r, pipe_x_n_s;
  logic [9:0]  pipe_y_top_r, pipe_y_top_n_s;
  logic [9:0]  pipe_y_bot_r, pipe_y_bot_n_s;
  logic [7:0]  score_r, score_n_s;
  logic        start_evt_s;
  logic [9:0]  spawn_top_s;
  logic [9:0]  spawn_bot_s;

  // One event per press: button high while last cycle's copy was low.
  assign start_evt_s = start_button & ~start_d_r;

  // New opening drawn from the current LFSR value; range 40..295 / 160..415.
  assign spawn_top_s = GAP_MIN_C + {2'b00, lfsr_r};
  assign spawn_bot_s = spawn_top_s + GAP_C;

  // Next-state and next-datapath decode; every register holds by default.
  always_comb begin
    state_n_s      = state_r;
    pipe_x_n_s     = pipe_x_r;
    pipe_y_top_n_s = pipe_y_top_r;
    pipe_y_bot_n_s = pipe_y_bot_r;
    score_n_s      = score_r;
    case (state_r)
      IDLE: begin
        if (start_evt_s) begin
          state_n_s      = RUN;
          pipe_x_n_s     = SPAWN_X_C;
          pipe_y_top_n_s = spawn_top_s;
          pipe_y_bot_n_s = spawn_bot_s;
          score_n_s      = 8'd0;
        end else begin
          state_n_s = IDLE;
        end
      end
      RUN: begin
        // Collision wins over a coincident tick: the pipe freezes where it is.
        if (collided) begin
          state_n_s = OVER;
        end else if (tick) begin
          // Compare before subtracting so pipe_x can never wrap below zero.
          if (pipe_x_r > SPEED_C) begin
            pipe_x_n_s = pipe_x_r - SPEED_C;
          end else begin
            pipe_x_n_s     = SPAWN_X_C;
            pipe_y_top_n_s = spawn_top_s;
            pipe_y_bot_n_s = spawn_bot_s;
            score_n_s      = (score_r == 8'd255) ? score_r : score_r + 8'd1;
          end
        end else begin
          state_n_s = RUN;
        end
      end
      OVER: begin
        if (start_evt_s) begin
          state_n_s      = RUN;
          pipe_x_n_s     = SPAWN_X_C;
          pipe_y_top_n_s = spawn_top_s;
          pipe_y_bot_n_s = spawn_bot_s;
          score_n_s      = 8'd0;
        end else begin
          state_n_s = OVER;
        end
      end
      default: begin
        state_n_s = IDLE;
      end
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_n_s;
    end
  end

  // Datapath registers, start-edge copy and free-running LFSR.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      start_d_r    <= 1'b0;
      lfsr_r       <= LFSR_SEED;
      pipe_x_r     <= SPAWN_X_C;
      pipe_y_top_r <= RST_TOP_C;
      pipe_y_bot_r <= RST_BOT_C;
      score_r      <= 8'd0;
    end else begin
      start_d_r    <= start_button;
      lfsr_r       <= lfsr_next(lfsr_r);
      pipe_x_r     <= pipe_x_n_s;
      pipe_y_top_r <= pipe_y_top_n_s;
      pipe_y_bot_r <= pipe_y_bot_n_s;
      score_r      <= score_n_s;
    end
  end

  assign pipe_x     = pipe_x_r;
  assign pipe_y_top = pipe_y_top_r;
  assign pipe_y_bot = pipe_y_bot_r;
  assign score      = score_r;
  assign running    = (state_r == RUN);
  assign game_over  = (state_r == OVER);

endmodule
